// File: rtl/reorder_buffer.sv
// Circular reorder buffer: in-order allocate, out-of-order writeback by tag,
// in-order commit with mispredict flush, plus youngest-writer operand lookup.
module reorder_buffer #(
    parameter  int DEPTH  = 8,
    parameter  int WIDTH  = 32,
    parameter  int AREG_W = 5,
    localparam int TAG_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              alloc_valid,
    output logic              alloc_ready,
    input  logic [AREG_W-1:0] alloc_rd,
    input  logic              alloc_rf_w_en,
    input  logic              alloc_is_store,
    input  logic [WIDTH-1:0]  alloc_pc,
    output logic [TAG_W-1:0]  alloc_tag,
    input  logic              wb_valid,
    input  logic [TAG_W-1:0]  wb_tag,
    input  logic [WIDTH-1:0]  wb_data,
    input  logic              wb_mispredict,
    input  logic [WIDTH-1:0]  wb_target,
    input  logic [AREG_W-1:0] src1_addr,
    input  logic [AREG_W-1:0] src2_addr,
    output logic              src1_hit,
    output logic              src1_ready,
    output logic [WIDTH-1:0]  src1_data,
    output logic              src2_hit,
    output logic              src2_ready,
    output logic [WIDTH-1:0]  src2_data,
    output logic              commit_valid,
    output logic [AREG_W-1:0] commit_rd,
    output logic              commit_rf_w_en,
    output logic              commit_is_store,
    output logic [WIDTH-1:0]  commit_data,
    output logic [WIDTH-1:0]  commit_pc,
    output logic              flush_o,
    output logic [WIDTH-1:0]  flush_pc,
    output logic [TAG_W:0]    count
);

    logic [DEPTH-1:0]  valid_q, done_q, mispred_q, rf_w_en_q, is_store_q;
    logic [AREG_W-1:0] rd_q     [DEPTH];
    logic [WIDTH-1:0]  pc_q     [DEPTH];
    logic [WIDTH-1:0]  value_q  [DEPTH];
    logic [WIDTH-1:0]  target_q [DEPTH];
    logic [TAG_W-1:0]  head, tail;
    logic [TAG_W-1:0]  src1_idx, src2_idx;
    logic              alloc_fire, wb_fire;

    assign commit_valid    = (count != '0) && valid_q[head] && done_q[head];
    assign flush_o         = commit_valid && mispred_q[head];
    assign flush_pc        = target_q[head];
    assign alloc_ready     = (count < (TAG_W+1)'(DEPTH)) && !flush_o;
    assign alloc_fire      = alloc_valid && alloc_ready;
    // A writeback landing in a flush cycle would target a discarded entry.
    assign wb_fire         = wb_valid && valid_q[wb_tag] && !flush_o;
    assign alloc_tag       = tail;
    assign commit_rd       = rd_q[head];
    assign commit_rf_w_en  = commit_valid && rf_w_en_q[head];
    assign commit_is_store = commit_valid && is_store_q[head];
    assign commit_data     = value_q[head];
    assign commit_pc       = pc_q[head];

    always_ff @(posedge clk) begin
        if (reset) begin
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            valid_q   <= '0;
            done_q    <= '0;
            mispred_q <= '0;
        end else if (flush_o) begin
            // The mispredicted head retires; everything younger is dropped.
            valid_q <= '0;
            head    <= head + TAG_W'(1);
            tail    <= head + TAG_W'(1);
            count   <= '0;
        end else begin
            if (wb_fire) begin
                done_q[wb_tag]    <= 1'b1;
                mispred_q[wb_tag] <= wb_mispredict;
            end
            if (commit_valid) begin
                valid_q[head] <= 1'b0;
                head          <= head + TAG_W'(1);
            end
            if (alloc_fire) begin
                valid_q[tail]   <= 1'b1;
                done_q[tail]    <= 1'b0;
                mispred_q[tail] <= 1'b0;
                tail            <= tail + TAG_W'(1);
            end
            count <= count + (TAG_W+1)'(alloc_fire) - (TAG_W+1)'(commit_valid);
        end
    end

    always_ff @(posedge clk) begin
        if (alloc_fire) begin
            rd_q[tail]       <= alloc_rd;
            rf_w_en_q[tail]  <= alloc_rf_w_en;
            is_store_q[tail] <= alloc_is_store;
            pc_q[tail]       <= alloc_pc;
        end
        if (wb_fire) begin
            value_q[wb_tag]  <= wb_data;
            target_q[wb_tag] <= wb_target;
        end
    end

    // Walk head -> tail-1; the last match seen is the youngest writer.
    function automatic logic [TAG_W:0] youngest_writer(input logic [AREG_W-1:0] addr);
        logic [TAG_W-1:0] idx;
        logic [TAG_W:0]   found;
        found = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + TAG_W'(i);
            if (addr != '0 && valid_q[idx] && rf_w_en_q[idx] && rd_q[idx] == addr)
                found = {1'b1, idx};
        end
        return found;
    endfunction

    always_comb begin
        {src1_hit, src1_idx} = youngest_writer(src1_addr);
        {src2_hit, src2_idx} = youngest_writer(src2_addr);
        src1_ready = src1_hit && done_q[src1_idx];
        src2_ready = src2_hit && done_q[src2_idx];
        src1_data  = src1_hit ? value_q[src1_idx] : '0;
        src2_data  = src2_hit ? value_q[src2_idx] : '0;
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed stimulus for reorder_buffer; commits are checked by a scoreboard monitor.
module tb_reorder_buffer;
    localparam int DEPTH  = 8;
    localparam int WIDTH  = 32;
    localparam int AREG_W = 5;
    localparam int TAG_W  = 3;

    logic              clk = 1'b0;
    logic              reset;
    logic              alloc_valid, alloc_ready, alloc_rf_w_en, alloc_is_store;
    logic [AREG_W-1:0] alloc_rd;
    logic [WIDTH-1:0]  alloc_pc;
    logic [TAG_W-1:0]  alloc_tag;
    logic              wb_valid, wb_mispredict;
    logic [TAG_W-1:0]  wb_tag;
    logic [WIDTH-1:0]  wb_data, wb_target;
    logic [AREG_W-1:0] src1_addr, src2_addr;
    logic              src1_hit, src1_ready, src2_hit, src2_ready;
    logic [WIDTH-1:0]  src1_data, src2_data;
    logic              commit_valid, commit_rf_w_en, commit_is_store, flush_o;
    logic [AREG_W-1:0] commit_rd;
    logic [WIDTH-1:0]  commit_data, commit_pc, flush_pc;
    logic [TAG_W:0]    count;

    reorder_buffer #(.DEPTH(DEPTH), .WIDTH(WIDTH), .AREG_W(AREG_W)) dut (
        .clk(clk), .reset(reset),
        .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_rd(alloc_rd),
        .alloc_rf_w_en(alloc_rf_w_en), .alloc_is_store(alloc_is_store),
        .alloc_pc(alloc_pc), .alloc_tag(alloc_tag),
        .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_data(wb_data),
        .wb_mispredict(wb_mispredict), .wb_target(wb_target),
        .src1_addr(src1_addr), .src2_addr(src2_addr),
        .src1_hit(src1_hit), .src1_ready(src1_ready), .src1_data(src1_data),
        .src2_hit(src2_hit), .src2_ready(src2_ready), .src2_data(src2_data),
        .commit_valid(commit_valid), .commit_rd(commit_rd),
        .commit_rf_w_en(commit_rf_w_en), .commit_is_store(commit_is_store),
        .commit_data(commit_data), .commit_pc(commit_pc),
        .flush_o(flush_o), .flush_pc(flush_pc), .count(count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]  rd;
        logic        we;
        logic        st;
        logic [31:0] data;
        logic [31:0] pc;
        logic        fl;
        logic [31:0] fpc;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        alloc_valid = 1'b0;
        wb_valid    = 1'b0;
        reset       = 1'b1;
        tick();
        reset       = 1'b0;
    endtask

    task automatic expect_commit(input logic [4:0] rd, input logic we, input logic st,
                                 input logic [31:0] data, input logic [31:0] pc,
                                 input logic fl, input logic [31:0] fpc);
        exp_q.push_back('{rd, we, st, data, pc, fl, fpc});
    endtask

    task automatic alloc(input logic [4:0] rd, input logic we, input logic st,
                         input logic [31:0] pc, input logic [2:0] tag);
        check("alloc_ready", alloc_ready, 1);
        check("alloc_tag", alloc_tag, tag);
        alloc_valid    = 1'b1;
        alloc_rd       = rd;
        alloc_rf_w_en  = we;
        alloc_is_store = st;
        alloc_pc       = pc;
        tick();
        alloc_valid    = 1'b0;
    endtask

    task automatic wb(input logic [2:0] tag, input logic [31:0] data,
                      input logic mp, input logic [31:0] tgt);
        wb_valid      = 1'b1;
        wb_tag        = tag;
        wb_data       = data;
        wb_mispredict = mp;
        wb_target     = tgt;
        tick();
        wb_valid      = 1'b0;
    endtask

    // Scoreboard monitor: every retirement must match the next expected commit.
    always @(negedge clk) begin
        if (reset === 1'b0 && commit_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_commit: rd=%0d pc=0x%0h, required no commit", commit_rd, commit_pc);
            end else begin
                e = exp_q.pop_front();
                check("commit_rd", commit_rd, e.rd);
                check("commit_rf_w_en", commit_rf_w_en, e.we);
                check("commit_is_store", commit_is_store, e.st);
                check("commit_data", commit_data, e.data);
                check("commit_pc", commit_pc, e.pc);
                check("commit_flush", flush_o, e.fl);
                if (e.fl) check("flush_pc", flush_pc, e.fpc);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; alloc_valid = 1'b0; alloc_rd = '0; alloc_rf_w_en = 1'b0;
        alloc_is_store = 1'b0; alloc_pc = '0; wb_valid = 1'b0; wb_tag = '0;
        wb_data = '0; wb_mispredict = 1'b0; wb_target = '0;
        src1_addr = 5'd1; src2_addr = 5'd0;

        // Reset state, fill to full, held-off alloc, first commit
        do_reset();
        check("rst_alloc_ready", alloc_ready, 1);
        check("rst_commit_valid", commit_valid, 0);
        check("rst_flush", flush_o, 0);
        check("rst_count", count, 0);
        check("rst_src1_hit", src1_hit, 0);
        expect_commit(5'd1, 1'b1, 1'b0, 32'h1000, 32'h100, 1'b0, 32'h0);
        for (int i = 0; i < 8; i++)
            alloc(5'(i + 1), 1'b1, 1'b0, 32'h100 + 32'(4 * i), 3'(i));
        check("full_count", count, 8);
        check("full_alloc_ready", alloc_ready, 0);
        check("full_alloc_tag", alloc_tag, 0);
        alloc_valid = 1'b1;
        alloc_rd    = 5'd9;
        wb(3'd0, 32'h1000, 1'b0, 32'h0);
        check("full_commit_valid", commit_valid, 1);
        check("full_commit_rd", commit_rd, 1);
        check("full_commit_no_alloc", alloc_ready, 0);
        check("full_count_hold", count, 8);
        tick();
        check("after_commit_count", count, 7);
        check("after_commit_ready", alloc_ready, 1);
        alloc_valid = 1'b0;

        // Out-of-order completion, in-order retirement
        do_reset();
        expect_commit(5'd1, 1'b1, 1'b0, 32'h10, 32'h200, 1'b0, 32'h0);
        expect_commit(5'd2, 1'b0, 1'b1, 32'h20, 32'h204, 1'b0, 32'h0);
        expect_commit(5'd3, 1'b1, 1'b0, 32'h30, 32'h208, 1'b0, 32'h0);
        alloc(5'd1, 1'b1, 1'b0, 32'h200, 3'd0);
        alloc(5'd2, 1'b0, 1'b1, 32'h204, 3'd1);
        alloc(5'd3, 1'b1, 1'b0, 32'h208, 3'd2);
        wb(3'd2, 32'h30, 1'b0, 32'h0);
        check("ooo_wait2", commit_valid, 0);
        wb(3'd1, 32'h20, 1'b0, 32'h0);
        check("ooo_wait1", commit_valid, 0);
        wb(3'd0, 32'h10, 1'b0, 32'h0);
        for (int k = 0; k < 3; k++) begin
            check("ooo_commit_valid", commit_valid, 1);
            check("ooo_commit_rd", commit_rd, 32'(k + 1));
            check("ooo_count", count, 32'(3 - k));
            tick();
        end
        check("ooo_drained", commit_valid, 0);
        check("ooo_count0", count, 0);

        // Pointer wrap over 20 round trips
        do_reset();
        for (int i = 0; i < 20; i++) begin
            expect_commit(5'((i % 31) + 1), 1'b1, 1'b0, 32'h500 + 32'(i),
                          32'h1000 + 32'(4 * i), 1'b0, 32'h0);
            alloc(5'((i % 31) + 1), 1'b1, 1'b0, 32'h1000 + 32'(4 * i), 3'(i % 8));
            check("wrap_count1", count, 1);
            wb(3'(i % 8), 32'h500 + 32'(i), 1'b0, 32'h0);
            check("wrap_commit_valid", commit_valid, 1);
            tick();
            check("wrap_count0", count, 0);
        end

        // Mispredict flush at head
        do_reset();
        expect_commit(5'd1, 1'b1, 1'b0, 32'h11, 32'h300, 1'b0, 32'h0);
        expect_commit(5'd2, 1'b1, 1'b0, 32'h22, 32'h304, 1'b1, 32'h400);
        for (int i = 0; i < 5; i++)
            alloc(5'(i + 1), 1'b1, 1'b0, 32'h300 + 32'(4 * i), 3'(i));
        wb(3'd2, 32'h33, 1'b0, 32'h0);
        wb(3'd3, 32'h44, 1'b0, 32'h0);
        wb(3'd4, 32'h55, 1'b0, 32'h0);
        wb(3'd1, 32'h22, 1'b1, 32'h400);
        wb(3'd0, 32'h11, 1'b0, 32'h0);
        check("mp_tag0_commit", commit_valid, 1);
        check("mp_tag0_noflush", flush_o, 0);
        tick();
        check("mp_flush", flush_o, 1);
        check("mp_flush_pc", flush_pc, 32'h400);
        check("mp_flush_ready", alloc_ready, 0);
        check("mp_flush_count", count, 4);
        tick();
        check("mp_count0", count, 0);
        check("mp_no_commit", commit_valid, 0);
        check("mp_alloc_tag", alloc_tag, 2);
        check("mp_alloc_ready", alloc_ready, 1);
        tick();
        tick();
        check("mp_still_idle", commit_valid, 0);
        expect_commit(5'd6, 1'b1, 1'b0, 32'h66, 32'h320, 1'b0, 32'h0);
        alloc(5'd6, 1'b1, 1'b0, 32'h320, 3'd2);
        wb(3'd2, 32'h66, 1'b0, 32'h0);
        check("mp_resume_commit", commit_valid, 1);
        tick();

        // Operand lookup: youngest writer, rd=0 and rf_w_en=0 excluded
        do_reset();
        expect_commit(5'd5, 1'b1, 1'b0, 32'hAA, 32'h600, 1'b0, 32'h0);
        expect_commit(5'd5, 1'b1, 1'b0, 32'hBB, 32'h604, 1'b0, 32'h0);
        alloc(5'd5, 1'b1, 1'b0, 32'h600, 3'd0);
        alloc(5'd5, 1'b1, 1'b0, 32'h604, 3'd1);
        alloc(5'd0, 1'b1, 1'b0, 32'h608, 3'd2);
        alloc(5'd5, 1'b0, 1'b0, 32'h60c, 3'd3);
        wb(3'd0, 32'hAA, 1'b0, 32'h0);
        src1_addr = 5'd5;
        src2_addr = 5'd7;
        #1;
        check("lk_hit", src1_hit, 1);
        check("lk_not_ready", src1_ready, 0);
        check("lk_miss_hit", src2_hit, 0);
        check("lk_miss_ready", src2_ready, 0);
        check("lk_miss_data", src2_data, 0);
        tick();
        wb(3'd1, 32'hBB, 1'b0, 32'h0);
        check("lk_ready", src1_ready, 1);
        check("lk_data", src1_data, 32'hBB);
        src1_addr = 5'd0;
        src2_addr = 5'd5;
        #1;
        check("lk_r0_hit", src1_hit, 0);
        check("lk_r0_ready", src1_ready, 0);
        check("lk_src2_data", src2_data, 32'hBB);
        tick();
        check("lk_no_writer", src2_hit, 0);

        // Reset with live entries, then stale writebacks are ignored
        do_reset();
        for (int i = 0; i < 5; i++)
            alloc(5'(i + 10), 1'b1, 1'b0, 32'h700 + 32'(4 * i), 3'(i));
        wb(3'd1, 32'h99, 1'b0, 32'h0);
        check("mid_count5", count, 5);
        check("mid_no_commit", commit_valid, 0);
        reset    = 1'b1;
        wb_valid = 1'b1;
        wb_tag   = 3'd0;
        tick();
        reset    = 1'b0;
        wb_valid = 1'b0;
        check("mid_rst_count", count, 0);
        check("mid_rst_commit", commit_valid, 0);
        check("mid_rst_tag", alloc_tag, 0);
        wb(3'd0, 32'h77, 1'b0, 32'h0);
        check("stale_wb_ignored", commit_valid, 0);
        expect_commit(5'd9, 1'b1, 1'b0, 32'h88, 32'h800, 1'b0, 32'h0);
        alloc(5'd9, 1'b1, 1'b0, 32'h800, 3'd0);
        check("fresh_not_done", commit_valid, 0);
        wb(3'd0, 32'h88, 1'b0, 32'h0);
        check("fresh_commit", commit_valid, 1);
        tick();
        tick();

        check("scoreboard_drained", 32'(exp_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
